// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads instruction memory over req/ack and holds one instruction for
// decode. Optional misaligned-redirect trap is enabled by defining FETCH_ALIGN_CHECK_EN.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_stall,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  output logic [31:0] o_instruction,
  output logic [31:0] o_pc_out,
  output logic        o_valid,
  output logic        o_fault
);

  typedef enum logic [1:0] {StIdle, StFetch, StHold, StDrain} state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic [31:0] r_pend_pc;
  logic [31:0] w_pend_next;
  logic [31:0] r_instr;
  logic [31:0] w_instr_next;
  logic [31:0] r_pc_out;
  logic [31:0] w_pc_out_next;
  logic [31:0] w_target;
  logic        w_misalign;
  logic        w_redirect;
  logic        w_bad;
  logic        w_fault;

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_fault;

  assign w_target   = i_branch_target;
  assign w_misalign = |i_branch_target[1:0];
  assign w_fault    = r_fault;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_fault <= 1'b0;
    end else if (w_bad) begin
      r_fault <= 1'b1;
    end
  end
`else
  logic w_unused_tgt_lsb;

  assign w_target         = {i_branch_target[31:2], 2'b00};
  assign w_misalign       = 1'b0;
  assign w_fault          = 1'b0;
  assign w_unused_tgt_lsb = ^i_branch_target[1:0];
`endif

  assign w_redirect = i_branch_taken & ~w_misalign;
  assign w_bad      = i_branch_taken & w_misalign;

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: redirects take priority over ack, stall and transfer
  always_comb begin
    w_state_next = r_state;
    if (w_bad) begin
      w_state_next = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (!w_fault) w_state_next = StFetch;
        end
        StFetch: begin
          if (w_redirect) begin
            w_state_next = i_imem_ack ? StFetch : StDrain;
          end else if (i_imem_ack) begin
            w_state_next = StHold;
          end
        end
        StHold: begin
          if (w_redirect || !i_stall) w_state_next = StFetch;
        end
        StDrain: begin
          if (i_imem_ack) w_state_next = StFetch;
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

  // Datapath next values
  always_comb begin
    w_pc_next     = r_pc;
    w_pend_next   = r_pend_pc;
    w_instr_next  = r_instr;
    w_pc_out_next = r_pc_out;
    if (w_bad) begin
      w_instr_next = NOP_INSTR;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_redirect) w_pc_next = w_target;
        end
        StFetch: begin
          if (w_redirect) begin
            if (i_imem_ack) begin
              w_pc_next = w_target;
            end else begin
              w_pend_next = w_target;
            end
          end else if (i_imem_ack) begin
            w_instr_next  = i_imem_rdata;
            w_pc_out_next = r_pc;
          end
        end
        StHold: begin
          if (w_redirect) begin
            w_pc_next    = w_target;
            w_instr_next = NOP_INSTR;
          end else if (!i_stall) begin
            w_pc_next    = r_pc + 32'd4;
            w_instr_next = NOP_INSTR;
          end
        end
        StDrain: begin
          if (w_redirect) w_pend_next = w_target;
          // A redirect arriving with the ack is the newest target
          if (i_imem_ack) w_pc_next = w_redirect ? w_target : r_pend_pc;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pc      <= RESET_PC;
      r_pend_pc <= RESET_PC;
      r_instr   <= NOP_INSTR;
      r_pc_out  <= RESET_PC;
    end else begin
      r_pc      <= w_pc_next;
      r_pend_pc <= w_pend_next;
      r_instr   <= w_instr_next;
      r_pc_out  <= w_pc_out_next;
    end
  end

  // Outputs
  always_comb begin
    o_imem_req    = (r_state == StFetch) || (r_state == StDrain);
    o_imem_addr   = r_pc;
    o_valid       = (r_state == StHold);
    o_instruction = r_instr;
    o_pc_out      = r_pc_out;
    o_fault       = w_fault;
  end

endmodule
